// File: rtl/clk_pll_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : clk_pll_sequencer
// Purpose  : Reset/lock sequencer for the 25 MHz clock-generator MMCM.
//            Holds the MMCM in reset for a fixed time, waits for lock with
//            a timeout and bounded retries, qualifies the lock over a settle
//            window, and then raises clk_ready. If lock drops while running,
//            it flags lock_lost and starts the bring-up again.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK          in   system clock, rising edge
//   RST_N        in   asynchronous active-low reset
//   restart      in   synchronous soft restart (1-cycle pulse is enough)
//   mmcm_locked  in   MMCM locked, asynchronous to CLK
//   mmcm_resetn  out  active-low MMCM reset, registered
//   clk_ready    out  generated clock stable, registered
//   lock_lost    out  sticky: lock dropped while in RUN
//   lock_err     out  sticky: retries exhausted (FAIL)
//   retry_cnt    out  lock timeouts in the current bring-up
//   state        out  debug: 0 RESET_HOLD, 1 WAIT_LOCK, 2 SETTLE, 3 RUN, 4 FAIL
// ============================================================================
module clk_pll_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           restart,
    input  logic                           mmcm_locked,
    output logic                           mmcm_resetn,
    output logic                           clk_ready,
    output logic                           lock_lost,
    output logic                           lock_err,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
    output logic [2:0]                     state
);

    // ------------------------------------------------------------------------
    // Derived widths and terminal counts
    // ------------------------------------------------------------------------
    localparam int C_MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int C_CNT_MAX = (C_MAX_A > SETTLE_CYCLES) ? C_MAX_A : SETTLE_CYCLES;
    // A single shared counter; it never has to hold more than C_CNT_MAX-1.
    localparam int C_CNT_W   = ($clog2(C_CNT_MAX) > 0) ? $clog2(C_CNT_MAX) : 1;
    localparam int C_RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [C_CNT_W-1:0]   C_RST_LAST    = C_CNT_W'(RST_CYCLES - 1);
    localparam logic [C_CNT_W-1:0]   C_TO_LAST     = C_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [C_CNT_W-1:0]   C_SETTLE_LAST = C_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [C_RETRY_W-1:0] C_RETRY_MAX   = C_RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAIL       = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic                 sync1_q;
    logic                 sync2_q;
    logic                 w_locked_s;

    state_t               state_q,       state_d;
    logic [C_CNT_W-1:0]   cnt_q,         cnt_d;
    logic [C_RETRY_W-1:0] retry_q,       retry_d;
    logic                 lock_lost_q,   lock_lost_d;
    logic                 lock_err_q,    lock_err_d;
    logic                 mmcm_resetn_q, mmcm_resetn_d;
    logic                 clk_ready_q,   clk_ready_d;

    // ------------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous MMCM lock indication.
    // Only the second stage is ever looked at by the FSM.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= mmcm_locked;
            sync2_q <= sync1_q;
        end
    end

    assign w_locked_s = sync2_q;

    // ------------------------------------------------------------------------
    // Next-state logic. Every state change reloads the counter with zero, so
    // the increment default is only ever kept while staying in a counting
    // state below its terminal count.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + C_CNT_W'(1);
        retry_d     = retry_q;
        lock_lost_d = lock_lost_q;
        lock_err_d  = lock_err_q;

        if (restart) begin
            // Soft restart overrides anything the current state would do.
            state_d     = ST_RESET_HOLD;
            cnt_d       = '0;
            retry_d     = '0;
            lock_lost_d = 1'b0;
            lock_err_d  = 1'b0;
        end else begin
            case (state_q)
                ST_RESET_HOLD: begin
                    if (cnt_q == C_RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end

                ST_WAIT_LOCK: begin
                    // Lock seen on the timeout cycle still counts as a lock.
                    if (w_locked_s) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q == C_TO_LAST) begin
                        cnt_d = '0;
                        if (retry_q == C_RETRY_MAX) begin
                            state_d    = ST_FAIL;
                            lock_err_d = 1'b1;
                        end else begin
                            state_d = ST_RESET_HOLD;
                            retry_d = retry_q + C_RETRY_W'(1);
                        end
                    end
                end

                ST_SETTLE: begin
                    // A lock that does not survive the settle window is a
                    // glitch, not a timeout, so the retry budget is untouched.
                    if (!w_locked_s) begin
                        state_d = ST_RESET_HOLD;
                        cnt_d   = '0;
                    end else if (cnt_q == C_SETTLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end

                ST_RUN: begin
                    cnt_d = '0;
                    if (!w_locked_s) begin
                        state_d     = ST_RESET_HOLD;
                        lock_lost_d = 1'b1;
                    end
                end

                ST_FAIL: begin
                    // Terminal until restart or RST_N; lock input ignored.
                    cnt_d = '0;
                end

                default: begin
                    state_d = ST_RESET_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs decoded from the next state so they change on the same
        // edge as the state itself.
        mmcm_resetn_d = !((state_d == ST_RESET_HOLD) || (state_d == ST_FAIL));
        clk_ready_d   = (state_d == ST_RUN);
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_RESET_HOLD;
            cnt_q         <= '0;
            retry_q       <= '0;
            lock_lost_q   <= 1'b0;
            lock_err_q    <= 1'b0;
            mmcm_resetn_q <= 1'b0;
            clk_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            lock_lost_q   <= lock_lost_d;
            lock_err_q    <= lock_err_d;
            mmcm_resetn_q <= mmcm_resetn_d;
            clk_ready_q   <= clk_ready_d;
        end
    end

    assign mmcm_resetn = mmcm_resetn_q;
    assign clk_ready   = clk_ready_q;
    assign lock_lost   = lock_lost_q;
    assign lock_err    = lock_err_q;
    assign retry_cnt   = retry_q;
    assign state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_pll_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_pll_sequencer
// Purpose  : Self-checking bench for clk_pll_sequencer. Stimulus pushes the
//            expected post-edge outputs into a scoreboard queue; a monitor
//            pops and compares after every rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_pll_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int SETTLE_CYCLES = 8;
    localparam int MAX_RETRY     = 2;

    // Phase codes equal to the debug state numbering.
    localparam int P_HOLD   = 0;
    localparam int P_WAIT   = 1;
    localparam int P_SETTLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAIL   = 4;

    logic       clk;
    logic       rst_n;
    logic       restart;
    logic       mmcm_locked;
    logic       mmcm_resetn;
    logic       clk_ready;
    logic       lock_lost;
    logic       lock_err;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    clk_pll_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .MAX_RETRY    (MAX_RETRY)
    ) u_dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .restart    (restart),
        .mmcm_locked(mmcm_locked),
        .mmcm_resetn(mmcm_resetn),
        .clk_ready  (clk_ready),
        .lock_lost  (lock_lost),
        .lock_err   (lock_err),
        .retry_cnt  (retry_cnt),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: phase + cycles remaining in that phase, and a queue
    // modelling the two-edge delay before the sequencer sees mmcm_locked.
    // ------------------------------------------------------------------------
    typedef struct {
        logic [2:0] st;
        logic       rn;
        logic       rdy;
        logic       lost;
        logic       err;
        logic [1:0] rc;
    } exp_t;

    exp_t sb[$];
    int   m_phase;
    int   m_remain;
    int   m_tries;
    logic m_lost;
    logic m_err;
    logic m_pipe[$];

    task automatic model_reset();
        m_phase  = P_HOLD;
        m_remain = RST_CYCLES;
        m_tries  = 0;
        m_lost   = 1'b0;
        m_err    = 1'b0;
        m_pipe   = {1'b0, 1'b0};
    endtask

    task automatic enter(input int ph, input int len);
        m_phase  = ph;
        m_remain = len;
    endtask

    // Advance the model by one rising edge with the given inputs; push the
    // outputs expected right after that edge.
    task automatic model_step(input logic r, input logic lk);
        logic seen;
        exp_t e;
        seen = m_pipe.pop_front();
        m_pipe.push_back(lk);
        if (r) begin
            enter(P_HOLD, RST_CYCLES);
            m_tries = 0;
            m_lost  = 1'b0;
            m_err   = 1'b0;
        end else begin
            case (m_phase)
                P_HOLD: begin
                    m_remain--;
                    if (m_remain == 0) enter(P_WAIT, LOCK_TIMEOUT);
                end
                P_WAIT: begin
                    if (seen) enter(P_SETTLE, SETTLE_CYCLES);
                    else begin
                        m_remain--;
                        if (m_remain == 0) begin
                            if (m_tries == MAX_RETRY) begin
                                enter(P_FAIL, 0);
                                m_err = 1'b1;
                            end else begin
                                m_tries++;
                                enter(P_HOLD, RST_CYCLES);
                            end
                        end
                    end
                end
                P_SETTLE: begin
                    if (!seen) enter(P_HOLD, RST_CYCLES);
                    else begin
                        m_remain--;
                        if (m_remain == 0) begin
                            enter(P_RUN, 0);
                            m_tries = 0;
                        end
                    end
                end
                P_RUN: begin
                    if (!seen) begin
                        m_lost = 1'b1;
                        enter(P_HOLD, RST_CYCLES);
                    end
                end
                default: ;
            endcase
        end
        e.st   = 3'(m_phase);
        e.rn   = !(m_phase == P_HOLD || m_phase == P_FAIL);
        e.rdy  = (m_phase == P_RUN);
        e.lost = m_lost;
        e.err  = m_err;
        e.rc   = 2'(m_tries);
        sb.push_back(e);
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb.state",       state,       e.st);
                check("sb.mmcm_resetn", mmcm_resetn, e.rn);
                check("sb.clk_ready",   clk_ready,   e.rdy);
                check("sb.lock_lost",   lock_lost,   e.lost);
                check("sb.lock_err",    lock_err,    e.err);
                check("sb.retry_cnt",   retry_cnt,   e.rc);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic cyc(input logic r, input logic lk);
        @(negedge clk);
        restart     = r;
        mmcm_locked = lk;
        if (rst_n) model_step(r, lk);
        @(posedge clk);
        #2;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n       = 1'b1;
        restart     = 1'b0;
        mmcm_locked = 1'b0;
        model_reset();
        model_step(1'b0, 1'b0);
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".state"},       state,       0);
        check({tag, ".mmcm_resetn"}, mmcm_resetn, 0);
        check({tag, ".clk_ready"},   clk_ready,   0);
        check({tag, ".lock_lost"},   lock_lost,   0);
        check({tag, ".lock_err"},    lock_err,    0);
        check({tag, ".retry_cnt"},   retry_cnt,   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        rst_n       = 1'b0;
        restart     = 1'b0;
        mmcm_locked = 1'b0;
        #2;
        check_reset_values("reset");

        // 1. Bring-up: release (1st hold edge), 3 more hold edges, 2 wait
        //    edges, then lock on the 3rd WAIT_LOCK cycle.
        release_rst();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            cyc(1'b0, 1'b1);
            if (i == 10) check("bringup.ready_early", clk_ready, 0);
            if (i == 11) check("bringup.ready_at_11", clk_ready, 1);
        end
        check("bringup.state",     state,     3);
        check("bringup.retry_cnt", retry_cnt, 0);

        // 4. Lock loss in RUN, then relock.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b0);
            check("loss.clk_ready", clk_ready, (i < 3) ? 1 : 0);
        end
        check("loss.lock_lost", lock_lost, 1);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1);
        check("relock.state",     state,     3);
        check("relock.lock_lost", lock_lost, 1);

        // 5b. Restart on the same edge the lock drop reaches the FSM.
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        check("rst_drop.state",     state,     0);
        check("rst_drop.lock_lost", lock_lost, 0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1);

        // 3. Settle glitch: drop lock for one cycle inside SETTLE.
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        check("glitch.in_settle", state, 2);
        cyc(1'b0, 1'b1);
        check("glitch.state",     state,     0);
        check("glitch.retry_cnt", retry_cnt, 0);
        check("glitch.clk_ready", clk_ready, 0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1);
        check("glitch.relock", state, 3);

        // 2. Timeout/retry into FAIL, then lock has no effect.
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 3 * (RST_CYCLES + LOCK_TIMEOUT) + 5; i++) cyc(1'b0, 1'b0);
        check("fail.state",       state,       4);
        check("fail.lock_err",    lock_err,    1);
        check("fail.mmcm_resetn", mmcm_resetn, 0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1);
        check("fail.sticky", state, 4);

        // 5a. Restart out of FAIL.
        cyc(1'b1, 1'b1);
        check("rst_fail.state",     state,     0);
        check("rst_fail.lock_err",  lock_err,  0);
        check("rst_fail.retry_cnt", retry_cnt, 0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1);

        // 6. Asynchronous reset between edges while in SETTLE.
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1);
        check("async.pre_state", state, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("async");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        release_rst();

        // Randomized lock patterns with occasional restarts.
        for (int n = 0; n < 1500; ) begin
            int   len;
            logic v;
            len = $urandom_range(1, 40);
            v   = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < len; j++) begin
                cyc(($urandom_range(0, 199) == 0), v);
                n++;
            end
        end

        check("sb.drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
